line_window_buffer: RTL and testbench

- Parametrised successor to the N-tap shift-register FIFO.
- Accepts a raster pixel stream and generates a K×K sliding window of pixels for the convolution datapath.
- Holds K-1 line delays (circular buffers) plus a K×K register window, so a new window is produced every accepted pixel.
- Line width is set at run time per frame. Tracks position and flags when the window holds K fully valid rows and columns.

---
 rtl/line_window_buffer.sv | 194 +++++++++++++++++++
 tb/tb_line_window_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_window_buffer.sv
// Line window buffer: turns a raster pixel stream into a KxK sliding window.
// K-1 circular line delays feed the rows of a KxK register window. Position
// counters qualify each window so the consumer knows when it is fully populated.

// One line delay: a circular buffer that reads the entry at ptr (written one
// line earlier) and overwrites it with the new input in the same accept cycle.
module lwb_line_buf #(
    parameter int B     = 8,
    parameter int W_MAX = 640,
    parameter int CW    = $clog2(W_MAX + 1)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [CW-1:0] ptr,
    input  logic [B-1:0]  wd,
    output logic [B-1:0]  rd
);

    localparam int AW = (W_MAX > 1) ? $clog2(W_MAX) : 1;

    // Storage is never cleared; stale entries are masked by win_valid upstream.
    logic [B-1:0] mem [W_MAX];

    // Read-before-write: rd is the value from one line ago at this pointer.
    assign rd = mem[ptr[AW-1:0]];

    // Overwrite the slot just read with the current row input.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[ptr[AW-1:0]] <= wd;
        end
    end

endmodule

// Top level: counters, width latch, line-delay array and register window.
module line_window_buffer #(
    parameter int B     = 8,
    parameter int K     = 3,
    parameter int W_MAX = 640,
    parameter int CW    = $clog2(W_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    line_width,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [B-1:0]     din,
    output logic [K*K*B-1:0] win,
    output logic             win_valid,
    output logic [CW-1:0]    out_col,
    output logic             out_eol
);

    localparam int RW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] WMAX_C   = CW'(W_MAX);
    localparam logic [CW-1:0] COL_FULL = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(K - 1);

    // Position state
    logic [CW-1:0] width_q;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] wr_ptr;

    // Effective values for the pixel being accepted this cycle; sof overrides
    // the registered state so the first pixel of a frame already sees the new
    // width and position 0.
    logic          accept;
    logic [CW-1:0] w_in;
    logic [CW-1:0] w_eff;
    logic [CW-1:0] col_eff;
    logic [RW-1:0] row_eff;
    logic [CW-1:0] ptr_eff;
    logic          col_last;
    logic          ptr_last;
    logic          full;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row_nxt;
    logic [CW-1:0] ptr_nxt;

    // Window and row taps; tap[K-1] is the live input, tap[0] the oldest line.
    logic [K-1:0][K-1:0][B-1:0] win_q;
    logic [K-1:0][B-1:0]        tap;
    logic [K-2:0][B-1:0]        lb_in;
    logic [K-2:0][B-1:0]        lb_out;

    logic          win_valid_q;
    logic [CW-1:0] out_col_q;
    logic          out_eol_q;

    // Reset wins over a coincident pixel, so it is simply dropped.
    assign accept = in_valid & ~rst;

    // Effective width/position and next-state arithmetic for the current pixel.
    always_comb begin
        w_in     = line_width;
        if ((line_width == '0) || (line_width > WMAX_C)) begin
            w_in = WMAX_C;
        end
        w_eff    = in_sof ? w_in : width_q;
        col_eff  = in_sof ? '0 : col_cnt;
        row_eff  = in_sof ? '0 : row_cnt;
        ptr_eff  = in_sof ? '0 : wr_ptr;

        col_last = (col_eff == (w_eff - CW'(1)));
        ptr_last = (ptr_eff == (w_eff - CW'(1)));

        col_nxt  = col_last ? '0 : (col_eff + CW'(1));
        ptr_nxt  = ptr_last ? '0 : (ptr_eff + CW'(1));
        row_nxt  = row_eff;
        if (col_last && (row_eff != ROW_LAST)) begin
            row_nxt = row_eff + RW'(1);
        end

        // Window covers K whole rows and K columns of the current line.
        full     = (row_eff == ROW_LAST) && (col_eff >= COL_FULL);
    end

    // Position counters and width latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            width_q <= WMAX_C;
            col_cnt <= '0;
            row_cnt <= '0;
            wr_ptr  <= '0;
        end else if (accept) begin
            width_q <= w_eff;
            col_cnt <= col_nxt;
            row_cnt <= row_nxt;
            wr_ptr  <= ptr_nxt;
        end
    end

    // Line-delay chain: each delay feeds the next, all sharing one pointer.
    assign tap[K-1] = din;

    for (genvar j = 0; j < K - 1; j++) begin : g_lb
        if (j == 0) begin : g_first
            assign lb_in[j] = din;
        end else begin : g_chain
            assign lb_in[j] = lb_out[j-1];
        end

        assign tap[K-2-j] = lb_out[j];

        lwb_line_buf #(
            .B     (B),
            .W_MAX (W_MAX),
            .CW    (CW)
        ) u_lb (
            .clk (clk),
            .we  (accept),
            .ptr (ptr_eff),
            .wd  (lb_in[j]),
            .rd  (lb_out[j])
        );
    end

    // Window shift: every row moves one column older and loads its tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= '0;
        end else if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][K-1] <= tap[r];
            end
        end
    end

    // Per-pixel status; valid is a single-cycle pulse, column/eol hold in gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_eol_q   <= 1'b0;
        end else begin
            win_valid_q <= accept & full;
            if (accept) begin
                out_col_q <= col_eff;
                out_eol_q <= col_last;
            end
        end
    end

    assign win       = win_q;
    assign win_valid = win_valid_q;
    assign out_col   = out_col_q;
    assign out_eol   = out_eol_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: random and directed pixel streams checked every
// cycle against a frame-history model (window element = pixel at a fixed
// offset back in the frame), plus a few hand-computed literal expectations.
module tb_line_window_buffer;

    localparam int B     = 8;
    localparam int K     = 3;
    localparam int W_MAX = 640;
    localparam int CW    = $clog2(W_MAX + 1);
    localparam int WB    = K * K * B;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CW-1:0] line_width = '0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [B-1:0]  din = '0;
    logic [WB-1:0] win;
    logic          win_valid;
    logic [CW-1:0] out_col;
    logic          out_eol;

    line_window_buffer #(.B(B), .K(K), .W_MAX(W_MAX), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .line_width (line_width),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .din        (din),
        .win        (win),
        .win_valid  (win_valid),
        .out_col    (out_col),
        .out_eol    (out_eol)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Model state: pixels of the current frame in arrival order.
    logic [B-1:0]  hist[$];
    int            m_w = W_MAX;
    logic          m_ok = 0, m_acc = 0, m_vld = 0, m_eol = 0, m_known = 0;
    logic [CW-1:0] m_col = '0;
    logic [WB-1:0] m_win = '0;

    // Expectations visible to the compare process for the edge just passed.
    logic          e_ok = 0, e_acc = 0, e_vld = 0, e_eol = 0, e_known = 0;
    logic [CW-1:0] e_col = '0;
    logic [WB-1:0] e_win = '0;

    task automatic model(input logic r, input logic v, input logic s,
                         input logic [CW-1:0] lw, input logic [B-1:0] d);
        int n, row;
        m_acc = 0;
        if (r) begin
            m_ok = 1; m_w = W_MAX; hist.delete();
            m_col = '0; m_eol = 0; m_vld = 0; m_known = 1; m_win = '0;
        end else if (v) begin
            m_acc = 1;
            if (s) begin
                m_w = (lw == 0 || int'(lw) > W_MAX) ? W_MAX : int'(lw);
                hist.delete();
            end
            hist.push_back(d);
            n     = hist.size() - 1;
            m_col = CW'(n % m_w);
            m_eol = (int'(m_col) == m_w - 1);
            row   = n / m_w;
            if (row > K - 1) row = K - 1;
            m_vld   = (row == K - 1) && (int'(m_col) >= K - 1);
            m_known = m_vld;
            if (m_vld) begin
                for (int rr = 0; rr < K; rr++)
                    for (int cc = 0; cc < K; cc++)
                        m_win[((rr*K)+cc)*B +: B] = hist[n - (K-1-rr)*m_w - (K-1-cc)];
            end
        end else begin
            m_vld = 0;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic s,
                        input logic [CW-1:0] lw, input logic [B-1:0] d);
        @(posedge clk);
        #1;
        e_ok = m_ok; e_acc = m_acc; e_vld = m_vld; e_col = m_col;
        e_eol = m_eol; e_known = m_known; e_win = m_win;
        rst = r; in_valid = v; in_sof = s; line_width = lw; din = d;
        model(r, v, s, lw, d);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, '0, '0);
    endtask

    // Stream rows x cols pixels; pattern selects row*16+col or random data.
    task automatic send(input int rows, input int cols, input int lw, input int gap,
                        input logic pat);
        for (int rr = 0; rr < rows; rr++)
            for (int cc = 0; cc < cols; cc++) begin
                step(0, 1, (rr == 0 && cc == 0), CW'(lw),
                     pat ? B'(rr*16 + cc) : B'($urandom));
                idle(gap);
            end
    endtask

    int            vcnt = 0, ecnt = 0;
    logic          grab = 0;
    logic [WB-1:0] first_win = '0;

    // Compare process: DUT outputs against the model every cycle.
    initial forever begin
        @(negedge clk);
        if (e_ok) begin
            chk("win_valid", WB'(win_valid), WB'(e_vld));
            chk("out_col", WB'(out_col), WB'(e_col));
            chk("out_eol", WB'(out_eol), WB'(e_eol));
            if (e_known) chk("win", win, e_win);
        end
        if (win_valid) begin
            vcnt++;
            if (grab) begin first_win = win; grab = 0; end
        end
        if (out_eol && e_acc) ecnt++;
    end

    logic [WB-1:0] lit_win;
    int base, ebase;

    initial begin
        lit_win = 72'h22_21_20_12_11_10_02_01_00;

        // Reset with a coincident pixel that must be dropped.
        step(1, 1, 0, '0, 8'hAA);
        step(1, 1, 0, '0, 8'hAA);
        idle(2);
        @(negedge clk); #1;
        chk("rst_win", win, '0);
        chk("rst_col", WB'(out_col), '0);
        chk("rst_vld", WB'(win_valid), '0);

        // Full 5x4 frame with a recognisable pattern.
        base = vcnt; ebase = ecnt; grab = 1;
        send(4, 5, 5, 0, 1);
        idle(2);
        chk("frame_nvalid", WB'(vcnt - base), WB'(6));
        chk("frame_first", first_win, lit_win);
        chk("frame_neol", WB'(ecnt - ebase), WB'(4));

        // Same frame with two idle cycles between pixels.
        base = vcnt; ebase = ecnt; grab = 1;
        send(4, 5, 5, 2, 1);
        idle(2);
        chk("gap_nvalid", WB'(vcnt - base), WB'(6));
        chk("gap_first", first_win, lit_win);
        chk("gap_neol", WB'(ecnt - ebase), WB'(4));

        // Mid-line restart: 7 pixels at width 5, then a fresh 3-wide frame.
        base = vcnt;
        send(1, 7, 5, 0, 0);
        send(4, 3, 3, 0, 0);
        idle(2);
        chk("restart_nvalid", WB'(vcnt - base), WB'(2));

        // Narrow lines never form a window.
        base = vcnt;
        send(5, 2, 2, 0, 0);
        idle(2);
        chk("narrow_nvalid", WB'(vcnt - base), WB'(0));

        // Clamp: width 0 and W_MAX+5 both act as W_MAX.
        base = vcnt; ebase = ecnt;
        send(1, W_MAX + 5, 0, 0, 0);
        idle(2);
        chk("clamp0_neol", WB'(ecnt - ebase), WB'(1));
        chk("clamp0_nvalid", WB'(vcnt - base), WB'(0));
        base = vcnt; ebase = ecnt;
        send(1, W_MAX + 5, W_MAX + 5, 0, 0);
        idle(2);
        chk("clampH_neol", WB'(ecnt - ebase), WB'(1));

        // Reset mid-frame at pixel (3,1), then resume without sof.
        send(1, 16, 5, 0, 0);
        step(1, 1, 0, '0, 8'h55);
        step(0, 0, 0, '0, '0);
        base = vcnt;
        step(0, 1, 0, '0, B'($urandom));
        idle(1);
        @(negedge clk); #1;
        chk("resume_col0", WB'(out_col), '0);
        for (int i = 1; i < 2 * W_MAX + 10; i++) step(0, 1, 0, '0, B'($urandom));
        idle(2);
        chk("resume_nvalid", WB'(vcnt - base), WB'(8));

        // Random stress: small widths, gaps, occasional sof and reset.
        step(0, 1, 1, CW'($urandom_range(1, 12)), B'($urandom));
        repeat (4000) begin
            logic r, v, s;
            r = ($urandom % 500) == 0;
            v = ($urandom % 4) != 0;
            s = v && (($urandom % 60) == 0);
            step(r, v, s, CW'($urandom_range(0, 12)), B'($urandom));
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
